// File: rtl/t80_bus_adapter.sv
// Z80-style strobe to single-request bus adapter with wait-state stretching.
// Optional WAIT watchdog is built in when T80_BUS_TIMEOUT_EN is defined.
module t80_bus_adapter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned MEM_WS  = 0,
    parameter int unsigned IO_WS   = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_mreq_n,
    input  logic          cpu_iorq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic          cpu_m1_n,
    input  logic          cpu_rfsh_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_do,
    output logic [7:0]    cpu_di,
    output logic          cpu_wait_n,
    output logic          bus_req,
    output logic          bus_we,
    output logic          bus_io,
    output logic [AW-1:0] bus_a,
    output logic [7:0]    bus_wd,
    input  logic          bus_ack,
    input  logic [7:0]    bus_rd,
    input  logic [7:0]    int_vector,
    output logic          timeout
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STRETCH, HOLD, INTA} state_t;

    state_t     state;
    logic [3:0] ws_cnt;
    logic [3:0] ws_load_c;
    logic       inta_c;
    logic       access_c;

    assign inta_c    = !cpu_m1_n && !cpu_iorq_n;
    assign access_c  = (!cpu_mreq_n || !cpu_iorq_n) && (!cpu_rd_n || !cpu_wr_n)
                       && cpu_rfsh_n && !inta_c;
    assign ws_load_c = bus_io ? 4'(IO_WS) : 4'(MEM_WS);

    // Wait is asserted in the detect cycle already so the CPU never samples a stale bus.
    assign cpu_wait_n = rst || !((state == IDLE && access_c) || state == REQ
                                 || state == WAIT || state == STRETCH);

`ifdef T80_BUS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] wait_cnt;
`else
    // Without the watchdog the WAIT state never aborts and TIMEOUT has no effect.
    assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ws_cnt   <= '0;
            cpu_di   <= 8'hFF;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_io   <= 1'b0;
            bus_a    <= '0;
            bus_wd   <= '0;
`ifdef T80_BUS_TIMEOUT_EN
            wait_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            bus_req <= 1'b0;
`ifdef T80_BUS_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (inta_c) begin
                        cpu_di <= int_vector;
                        state  <= INTA;
                    end else if (access_c) begin
                        bus_a   <= cpu_a;
                        bus_wd  <= cpu_do;
                        bus_we  <= !cpu_wr_n;
                        bus_io  <= !cpu_iorq_n;
                        bus_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (bus_ack) begin
                        if (!bus_we) cpu_di <= bus_rd;
                        ws_cnt <= ws_load_c;
                        state  <= (ws_load_c != 4'd0) ? STRETCH : HOLD;
                    end
`ifdef T80_BUS_TIMEOUT_EN
                    else if (state == REQ) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        cpu_di  <= 8'hFF;
                        timeout <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`else
                    else begin
                        state <= WAIT;
                    end
`endif
                end
                STRETCH: begin
                    ws_cnt <= ws_cnt - 4'd1;
                    if (ws_cnt == 4'd1) state <= HOLD;
                end
                HOLD: begin
                    if (cpu_mreq_n && cpu_iorq_n) state <= IDLE;
                end
                INTA: begin
                    if (cpu_iorq_n) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/t80_bus_adapter.md
T80_BUS_ADAPTER -- requirements
Module: t80_bus_adapter

Interface
REQ-001 Parameter AW, 16: CPU/bus address width in bits.
REQ-002 Parameter MEM_WS, 0: extra wait cycles after ack for memory accesses (0-15).
REQ-003 Parameter IO_WS, 1: extra wait cycles after ack for I/O accesses (0-15).
REQ-004 Parameter TIMEOUT, 255: maximum cycles spent in WAIT before abort (used only with macro).
REQ-005 clock  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n  in  1 each  active-low Z80 strobes from CPU core.
REQ-008 cpu_a  in  AW  CPU address; cpu_do  in  8  CPU write data.
REQ-009 cpu_di  out  8  read data to CPU (registered); cpu_wait_n  out  1  active-low wait to CPU.
REQ-010 bus_req  out  1  one-cycle request pulse; bus_we  out  1  1=write; bus_io  out  1  1=I/O space.
REQ-011 bus_a  out  AW  and bus_wd  out  8: registered address/write data, stable from REQ until return to IDLE.
REQ-012 bus_ack  in  1  completion strobe; bus_rd  in  8  read data valid with bus_ack.
REQ-013 int_vector  in  8  byte returned in interrupt-acknowledge cycles; timeout  out  1  abort pulse.

Function
REQ-014 States SHALL be IDLE, REQ, WAIT, STRETCH, HOLD, INTA.
REQ-015 Access detected in IDLE when (!mreq_n | !iorq_n) & (!rd_n | !wr_n) & rfsh_n & !(!m1_n & !iorq_n); capture cpu_a, cpu_do, bus_we=!wr_n, bus_io=!iorq_n; go REQ.
REQ-016 rd_n and wr_n both low SHALL be treated as write.
REQ-017 Refresh cycles (rfsh_n low) SHALL never produce bus_req.
REQ-018 REQ: bus_req=1 for exactly one cycle; next state WAIT unless bus_ack is high in same cycle (handled as in WAIT).
REQ-019 WAIT: on bus_ack, cpu_di<=bus_rd if read (unchanged if write); load counter with IO_WS or MEM_WS; go STRETCH if counter>0 else HOLD.
REQ-020 STRETCH: decrement counter each cycle; at count 1 go HOLD (exactly N stretch cycles).
REQ-021 cpu_wait_n SHALL be 0 combinationally when access detected in IDLE, and in REQ, WAIT, STRETCH; 1 otherwise.
REQ-022 HOLD: keep cpu_di; return to IDLE when cpu_mreq_n and cpu_iorq_n both high; no new access accepted before IDLE.
REQ-023 In IDLE, !m1_n & !iorq_n SHALL enter INTA: cpu_di<=int_vector, no bus_req, no wait; return to IDLE when iorq_n high.
REQ-024 bus_ack outside REQ/WAIT SHALL be ignored.
REQ-025 Total CPU-visible wait for access with ack k cycles after bus_req: k+1+N cycles (N = MEM_WS or IO_WS).

Reset
REQ-026 reset SHALL force IDLE immediately, including mid-access: cpu_di=8'hFF, cpu_wait_n=1, bus_req=0, bus_we=0, bus_io=0, bus_a=0, bus_wd=0, timeout=0, counters 0.
REQ-027 bus_ack pending at reset release SHALL be ignored.

Configuration
REQ-028 Macro T80_BUS_TIMEOUT_EN defined: WAIT cycle counter; after TIMEOUT cycles without bus_ack, cpu_di<=8'hFF, timeout=1 for one cycle, go HOLD (no stretch).
REQ-029 Macro undefined: WAIT lasts until bus_ack indefinitely; timeout tied 0; TIMEOUT unused.

Verification
REQ-030 Memory read 0x1234, MEM_WS=0, bus_ack 2 cycles after bus_req with bus_rd=0xA5 -> one bus_req, bus_we=0, bus_io=0, wait_n low 3 cycles, cpu_di=0xA5.
REQ-031 I/O write port 0x00FE data 0x07, IO_WS=1, immediate ack -> bus_io=1, bus_we=1, bus_wd=0x07, wait_n low 2 cycles, cpu_di unchanged.
REQ-032 Interrupt ack (m1_n=0, iorq_n=0), int_vector=0xFF -> no bus_req, wait_n stays 1, cpu_di=0xFF; refresh cycle -> no bus_req.
REQ-033 reset asserted in WAIT -> same edge: wait_n=1, bus_req=0, cpu_di=0xFF; later ack ignored; next access handled normally.
REQ-034 T80_BUS_TIMEOUT_EN, TIMEOUT=8, no ack -> timeout pulse after 8 WAIT cycles, cpu_di=0xFF, wait_n released; without macro wait_n stays low.
